bus_dma_copier: RTL and testbench



---
 rtl/bus_dma_pkg.sv | 17 +
 rtl/bus_dma_buf.sv | 63 ++++++
 rtl/bus_dma_copier.sv | 238 +++++++++++++++++++++++
 tb/tb_bus_dma_copier.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the bus_dma_copier block-copy engine.
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RD_GAP = 3'd2,
        ST_WR     = 3'd3,
        ST_WR_GAP = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } dma_state_e;

    localparam logic [3:0]  BE_DWORD  = 4'b1111;
    localparam int unsigned ADDR_STEP = 4;

endpackage

// File: rtl/bus_dma_buf.sv
// Burst staging buffer: DEPTH registers filled through a write pointer and
// drained through a read pointer; clr rewinds both pointers.
module bus_dma_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    assign rdata = mem_q[rd_ptr_q];

    // Next-state for storage and both pointers
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/bus_dma_copier.sv
// Bus-master DMA copier: read burst into a local buffer, write it back, repeat.
// Optional BUS_DMA_FILL_EN adds fill/fill_data ports for pattern-fill transfers.
module bus_dma_copier
    import bus_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  m_enable,
    output logic                  m_wr_en,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [3:0]            m_be,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ready,
    input  logic                  m_bus_err
`ifdef BUS_DMA_FILL_EN
    ,
    input  logic                  fill,
    input  logic [DATA_WIDTH-1:0] fill_data
`endif
);

    localparam int CNT_W = 4;

    dma_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]      cyc_q, cyc_d;
    logic                  fill_q, fill_d;
    logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
    logic                  en_prev_q, en_prev_d;
    logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  m_enable_q, m_enable_d, m_wr_en_q, m_wr_en_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [3:0]            m_be_q, m_be_d;
    logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;

    logic                  fill_s;
    logic [DATA_WIDTH-1:0] fill_data_s;
    logic [CNT_W-1:0]      n_s;
    logic [ADDR_WIDTH-1:0] step_s;
    logic [LEN_WIDTH-1:0]  rem_next_s;
    logic                  misaligned_s, active_s, bus_fault_s;
    logic                  buf_clr_s, buf_wr_s, buf_rd_s;
    logic [DATA_WIDTH-1:0] buf_rdata_s;
    logic                  unused_ready_s;

`ifdef BUS_DMA_FILL_EN
    assign fill_s      = fill;
    assign fill_data_s = fill_data;
`else
    assign fill_s      = 1'b0;
    assign fill_data_s = '0;
`endif

    // The slave never stalls a burst, so ready carries no information here.
    assign unused_ready_s = m_ready;

    assign n_s          = (rem_q < LEN_WIDTH'(BURST)) ? CNT_W'(rem_q) : CNT_W'(BURST);
    assign step_s       = ADDR_WIDTH'(n_s) * ADDR_WIDTH'(ADDR_STEP);
    assign rem_next_s   = rem_q - LEN_WIDTH'(n_s);
    assign misaligned_s = (!fill_s && (src_addr[1:0] != 2'b00)) || (dst_addr[1:0] != 2'b00);
    assign active_s     = (state_q == ST_RD) || (state_q == ST_RD_GAP) ||
                          (state_q == ST_WR) || (state_q == ST_WR_GAP);
    assign bus_fault_s  = m_bus_err && (m_enable_q || en_prev_q) && active_s;

    bus_dma_buf #(
        .DEPTH (BURST),
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (buf_clr_s),
        .wr_en (buf_wr_s),
        .wdata (m_rdata),
        .rd_en (buf_rd_s),
        .rdata (buf_rdata_s)
    );

    // Transfer sequencing: state, address/length bookkeeping, buffer control
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        cyc_d       = cyc_q;
        fill_d      = fill_q;
        fill_data_d = fill_data_q;
        m_wdata_d   = '0;
        buf_clr_s   = 1'b0;
        buf_wr_s    = 1'b0;
        buf_rd_s    = 1'b0;
        if (bus_fault_s) begin
            state_d   = ST_ERR;
            buf_clr_s = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!start) begin
                        state_d = ST_IDLE;
                    end else if (misaligned_s) begin
                        state_d = ST_ERR;
                    end else if (len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        src_d       = src_addr;
                        dst_d       = dst_addr;
                        rem_d       = len;
                        cyc_d       = '0;
                        fill_d      = fill_s;
                        fill_data_d = fill_data_s;
                        buf_clr_s   = 1'b1;
                        state_d     = fill_s ? ST_WR : ST_RD;
                        m_wdata_d   = fill_s ? fill_data_s : '0;
                    end
                end
                ST_RD: begin
                    // Read data trails the enable by two cycles.
                    buf_wr_s = (cyc_q >= CNT_W'(2));
                    if (cyc_q == n_s + CNT_W'(1)) begin
                        state_d = ST_RD_GAP;
                        cyc_d   = '0;
                    end else begin
                        cyc_d = cyc_q + CNT_W'(1);
                    end
                end
                ST_RD_GAP: begin
                    state_d   = ST_WR;
                    cyc_d     = '0;
                    m_wdata_d = buf_rdata_s;
                    buf_rd_s  = 1'b1;
                end
                ST_WR: begin
                    if (cyc_q == n_s - CNT_W'(1)) begin
                        state_d = ST_WR_GAP;
                        cyc_d   = '0;
                    end else begin
                        cyc_d     = cyc_q + CNT_W'(1);
                        m_wdata_d = fill_q ? fill_data_q : buf_rdata_s;
                        buf_rd_s  = !fill_q;
                    end
                end
                ST_WR_GAP: begin
                    src_d     = src_q + step_s;
                    dst_d     = dst_q + step_s;
                    rem_d     = rem_next_s;
                    cyc_d     = '0;
                    buf_clr_s = 1'b1;
                    if (rem_next_s == '0) begin
                        state_d = ST_DONE;
                    end else if (fill_q) begin
                        state_d   = ST_WR;
                        m_wdata_d = fill_data_q;
                    end else begin
                        state_d = ST_RD;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs derived from the upcoming state
    always_comb begin
        m_enable_d = (state_d == ST_RD) || (state_d == ST_WR);
        m_wr_en_d  = (state_d == ST_WR);
        m_addr_d   = (state_d == ST_RD) ? src_d : ((state_d == ST_WR) ? dst_d : '0);
        m_be_d     = m_enable_d ? BE_DWORD : 4'b0000;
        busy_d     = (state_d == ST_RD) || (state_d == ST_RD_GAP) ||
                     (state_d == ST_WR) || (state_d == ST_WR_GAP);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
        en_prev_d  = m_enable_q;
    end

    // FSM and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            cyc_q       <= '0;
            fill_q      <= 1'b0;
            fill_data_q <= '0;
            en_prev_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_enable_q  <= 1'b0;
            m_wr_en_q   <= 1'b0;
            m_addr_q    <= '0;
            m_be_q      <= 4'b0000;
            m_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            cyc_q       <= cyc_d;
            fill_q      <= fill_d;
            fill_data_q <= fill_data_d;
            en_prev_q   <= en_prev_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            m_enable_q  <= m_enable_d;
            m_wr_en_q   <= m_wr_en_d;
            m_addr_q    <= m_addr_d;
            m_be_q      <= m_be_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign m_enable = m_enable_q;
    assign m_wr_en  = m_wr_en_q;
    assign m_addr   = m_addr_q;
    assign m_be     = m_be_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_bus_dma_copier.sv
// Self-checking bench for bus_dma_copier with a behavioural burst-mode slave.
module tb_bus_dma_copier;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len_i;
    logic        busy, done, err;
    logic        m_enable, m_wr_en;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata, m_rdata;
    logic        m_ready, m_bus_err;

    always #5 clk = ~clk;

    bus_dma_copier #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (16),
        .BURST      (BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len_i),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .m_enable  (m_enable),
        .m_wr_en   (m_wr_en),
        .m_addr    (m_addr),
        .m_be      (m_be),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_bus_err (m_bus_err)
    );

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] mem [logic [31:0]];
    int          en_cycles = 0, en_rises = 0, wr_count = 0, be_bad = 0, addr_moves = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Slave: latches the burst base on the first enabled edge, auto-increments,
    // and returns read word i one edge after it is addressed.
    task automatic slave_run();
        logic        en, we, act;
        logic [31:0] ad, wd, base, a, stage, nstage;
        logic [3:0]  be;
        int          off;
        act = 1'b0; stage = 32'h0; base = 32'h0; off = 0;
        forever begin
            @(posedge clk);
            en = m_enable; we = m_wr_en; ad = m_addr; wd = m_wdata; be = m_be;
            #1;
            nstage = stage;
            if (en === 1'b1) begin
                if (!act) begin
                    base = ad; off = 0; en_rises++;
                end
                if (ad !== base) addr_moves++;
                a = base + 32'(off * 4);
                if (we === 1'b1) begin
                    mem[a] = wd; wr_count++;
                end else begin
                    nstage = mem_rd(a);
                end
                off++; act = 1'b1; en_cycles++;
                if (be !== 4'hF) be_bad++;
            end else begin
                act = 1'b0;
                if (be !== 4'h0) be_bad++;
            end
            m_rdata = stage;
            stage   = nstage;
        end
    endtask

    task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int n_words, input bit preset);
        logic [31:0] exp_w[$];
        int t_exp, nb, ec_exp, rem, n, k, ec0, er0, wc0, bb0, am0;
        bit got_done, got_err, busy_ok, busy_at_end;
        exp_w.delete();
        for (int i = 0; i < n_words; i++) begin
            if (!preset) mem[src + 32'(4 * i)] = $urandom;
            exp_w.push_back(mem_rd(src + 32'(4 * i)));
        end
        rem = n_words; t_exp = 0; nb = 0; ec_exp = 0;
        while (rem > 0) begin
            n = (rem < BURST) ? rem : BURST;
            t_exp += 2 * n + 4; ec_exp += 2 * n + 2; nb++; rem -= n;
        end
        ec0 = en_cycles; er0 = en_rises; wc0 = wr_count; bb0 = be_bad; am0 = addr_moves;
        @(negedge clk);
        src_addr = src; dst_addr = dst; len_i = 16'(n_words); start = 1'b1;
        k = 0; got_done = 1'b0; got_err = 1'b0; busy_ok = 1'b1; busy_at_end = 1'b1;
        while (k < 300 && !got_done && !got_err) begin
            @(posedge clk); k++;
            @(negedge clk); start = 1'b0;
            got_done = (done === 1'b1); got_err = (err === 1'b1);
            if (!got_done && !got_err && busy !== 1'b1) busy_ok = 1'b0;
            busy_at_end = busy;
        end
        check({tag, " done"}, 32'(got_done), 32'd1);
        check({tag, " err"}, 32'(got_err), 32'd0);
        check({tag, " latency"}, 32'(k), 32'(t_exp + 1));
        check({tag, " busy during"}, 32'(busy_ok), 32'd1);
        check({tag, " busy at done"}, 32'(busy_at_end), 32'd0);
        @(negedge clk);
        check({tag, " done pulse"}, 32'(done), 32'd0);
        for (int i = 0; i < n_words; i++)
            check({tag, " data"}, mem_rd(dst + 32'(4 * i)), exp_w[i]);
        check({tag, " writes"}, 32'(wr_count - wc0), 32'(n_words));
        check({tag, " enable cycles"}, 32'(en_cycles - ec0), 32'(ec_exp));
        check({tag, " bursts"}, 32'(en_rises - er0), 32'(2 * nb));
        check({tag, " byte enables"}, 32'(be_bad - bb0), 32'd0);
        check({tag, " addr held"}, 32'(addr_moves - am0), 32'd0);
    endtask

    initial begin
        int k, ec0, err_j;
        bit got_err, got_done, busy_at_err;
        logic [31:0] r_src, r_dst;

        rst = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len_i = 16'h0;
        m_ready = 1'b1; m_bus_err = 1'b0; m_rdata = 32'h0;
        fork
            slave_run();
        join_none

        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset enable", 32'(m_enable), 32'd0);
        check("reset wr_en", 32'(m_wr_en), 32'd0);
        check("reset addr", m_addr, 32'h0);
        check("reset be", 32'(m_be), 32'd0);
        check("reset wdata", m_wdata, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mem[32'h10] = 32'h11223344; mem[32'h14] = 32'h55667788;
        mem[32'h18] = 32'h99AABBCC; mem[32'h1C] = 32'hDDEEFF00;
        run_copy("copy4", 32'h10, 32'h40, 4, 1'b1);
        check("copy4 word0 const", mem_rd(32'h40), 32'h11223344);
        check("copy4 word3 const", mem_rd(32'h4C), 32'hDDEEFF00);

        run_copy("multi10", 32'h100, 32'h200, 10, 1'b0);
        run_copy("wrap6", 32'hFFFF_FFF8, 32'h3000, 6, 1'b0);
        run_copy("zero", 32'h100, 32'h2000, 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            r_src = 32'h1000 + 32'(r * 512) + 32'(4 * $urandom_range(0, 15));
            r_dst = 32'h9000 + 32'(r * 512) + 32'(4 * $urandom_range(0, 15));
            run_copy("random", r_src, r_dst, int'($urandom_range(1, 12)), 1'b0);
        end

        // Unaligned source: immediate error, no bus traffic.
        ec0 = en_cycles;
        @(negedge clk);
        src_addr = 32'h12; dst_addr = 32'h40; len_i = 16'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        check("unaligned err", 32'(err), 32'd1);
        check("unaligned done", 32'(done), 32'd0);
        check("unaligned busy", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
        check("unaligned no bus", 32'(en_cycles - ec0), 32'd0);

        // Slave error during the write burst.
        for (int i = 0; i < 8; i++) mem[32'h500 + 32'(4 * i)] = $urandom;
        @(negedge clk);
        src_addr = 32'h500; dst_addr = 32'h600; len_i = 16'd8; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        k = 0;
        while (m_wr_en !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        check("buserr reached write", 32'(m_wr_en), 32'd1);
        m_bus_err = 1'b1;
        got_err = 1'b0; got_done = 1'b0; busy_at_err = 1'b1; err_j = -1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            m_bus_err = 1'b0;
            if (err === 1'b1 && !got_err) begin
                got_err = 1'b1; busy_at_err = busy; err_j = j;
            end
            if (done === 1'b1) got_done = 1'b1;
        end
        check("buserr err", 32'(got_err), 32'd1);
        check("buserr err timing", 32'(err_j), 32'd0);
        check("buserr no done", 32'(got_done), 32'd0);
        check("buserr busy", 32'(busy_at_err), 32'd0);
        ec0 = en_cycles;
        repeat (5) @(negedge clk);
        check("buserr bus quiet", 32'(en_cycles - ec0), 32'd0);

        // Asynchronous reset in the middle of a write burst.
        for (int i = 0; i < 8; i++) mem[32'h700 + 32'(4 * i)] = $urandom;
        @(negedge clk);
        src_addr = 32'h700; dst_addr = 32'h780; len_i = 16'd8; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        k = 0;
        while (m_wr_en !== 1'b1 && k < 100) begin
            @(negedge clk); k++;
        end
        check("rst reached write", 32'(m_wr_en), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst enable", 32'(m_enable), 32'd0);
        check("rst wr_en", 32'(m_wr_en), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst addr", m_addr, 32'h0);
        check("rst be", 32'(m_be), 32'd0);
        @(negedge clk);
        check("rst done", 32'(done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_copy("after rst", 32'h700, 32'h800, 5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
